// File: rtl/quadenc_pkg.sv
// quadenc_pkg: shared state constants, decode modes and step classification.
package quadenc_pkg;
  localparam logic [1:0] QE_S00 = 2'b00, QE_S01 = 2'b01, QE_S11 = 2'b11, QE_S10 = 2'b10;
  localparam int QE_X1 = 1, QE_X2 = 2, QE_X4 = 4;
  typedef enum logic [1:0] {STEP_NONE, STEP_CW, STEP_ACW, STEP_ERR} step_e;
  // Returns the counted direction of a prev->cur move; legal moves the mode skips give STEP_NONE.
  function automatic step_e qe_decode(input logic [1:0] prev, input logic [1:0] cur, input int mode);
    logic lo, hi, cnt;
    lo = (prev == QE_S00 || prev == QE_S01) && (cur == QE_S00 || cur == QE_S01);
    hi = (prev == QE_S11 || prev == QE_S10) && (cur == QE_S11 || cur == QE_S10);
    cnt = mode == QE_X4 || (mode == QE_X2 && (lo || hi)) || (mode == QE_X1 && lo);
    if (cur == prev) return STEP_NONE;
    if (cur == {prev[0], ~prev[1]}) return cnt ? STEP_CW : STEP_NONE;
    if (cur == {~prev[0], prev[1]}) return cnt ? STEP_ACW : STEP_NONE;
    return STEP_ERR;
  endfunction
endpackage

// File: rtl/quadenc_counter_debounce.sv
// quadenc_debounce: 2-FF synchroniser plus DEB_LEN stable-level filter for one pin.
module quadenc_debounce #(
  parameter int DEB_LEN = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  logic [DEB_LEN-1:0] sh_q;
  logic q_q;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q <= '0;
      sh_q <= '0;
      q_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      sh_q <= {sh_q[DEB_LEN-2:0], sync_q[1]};
      q_q <= &sh_q ? 1'b1 : ~|sh_q ? 1'b0 : q_q;
    end
  end
  assign q_o = q_q;
endmodule

// File: rtl/quadenc_counter.sv
// quadenc_counter: debounced quadrature decoder with signed position, index and error detection.
module quadenc_counter
  import quadenc_pkg::*;
#(
  parameter int DEB_LEN  = 8,
  parameter int POS_W    = 16,
  parameter int DEC_MODE = 4,
  parameter int WRAP     = 1,
  parameter int IDX_CLR  = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    a_in,
  input  logic                    b_in,
  input  logic                    c_in,
  input  logic                    clr_in,
  output logic                    cw_out,
  output logic                    acw_out,
  output logic                    idx_out,
  output logic                    err_out,
  output logic                    err_flag_out,
  output logic signed [POS_W-1:0] pos_out
);
  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  logic a_v, b_v, c_v, idx_rise;
  logic [1:0] prev_q;
  logic c_prev_q, cw_q, acw_q, idx_q, err_q, flag_q;
  logic signed [POS_W-1:0] pos_q, pos_d;
  step_e step;
  quadenc_debounce #(.DEB_LEN(DEB_LEN)) u_deb_a (.clk_in(clk_in), .rst_in(rst_in), .d_i(a_in), .q_o(a_v));
  quadenc_debounce #(.DEB_LEN(DEB_LEN)) u_deb_b (.clk_in(clk_in), .rst_in(rst_in), .d_i(b_in), .q_o(b_v));
  quadenc_debounce #(.DEB_LEN(DEB_LEN)) u_deb_c (.clk_in(clk_in), .rst_in(rst_in), .d_i(c_in), .q_o(c_v));
  // Clears win over counting, so a step on a clear edge is pulsed but leaves pos at 0.
  always_comb begin
    step = qe_decode(prev_q, {a_v, b_v}, DEC_MODE);
    idx_rise = c_v & ~c_prev_q;
    pos_d = (clr_in || (IDX_CLR != 0 && idx_rise)) ? '0 :
            step == STEP_CW  ? ((WRAP == 0 && pos_q == POS_MAX) ? pos_q : pos_q + 1'b1) :
            step == STEP_ACW ? ((WRAP == 0 && pos_q == POS_MIN) ? pos_q : pos_q - 1'b1) :
            pos_q;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prev_q <= '0;
      c_prev_q <= 1'b0;
      cw_q <= 1'b0;
      acw_q <= 1'b0;
      idx_q <= 1'b0;
      err_q <= 1'b0;
      flag_q <= 1'b0;
      pos_q <= '0;
    end else begin
      prev_q <= {a_v, b_v};
      c_prev_q <= c_v;
      cw_q <= step == STEP_CW;
      acw_q <= step == STEP_ACW;
      idx_q <= idx_rise;
      err_q <= step == STEP_ERR;
      flag_q <= clr_in ? 1'b0 : flag_q | (step == STEP_ERR);
      pos_q <= pos_d;
    end
  end
  assign cw_out = cw_q;
  assign acw_out = acw_q;
  assign idx_out = idx_q;
  assign err_out = err_q;
  assign err_flag_out = flag_q;
  assign pos_out = pos_q;
endmodule

// File: tb/tb_quadenc_counter.sv
// tb_quadenc_counter: directed checks over four decoder configurations sharing the same pins.
module tb_quadenc_counter;
  logic clk = 1'b0, rst = 1'b1, a = 1'b0, b = 1'b0, c = 1'b0, clr = 1'b0;
  logic cw[4], acw[4], idx[4], err[4], flag[4];
  logic [7:0] pos[4];
  int cw_n[4], acw_n[4], idx_n[4], err_n[4];
  int tests = 0, fails = 0;
  logic [1:0] seq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  always #5 clk = ~clk;
  // d0: 4x wrap idx-clear, d1: 1x, d2: 2x, d3: 4x saturate without idx-clear
  quadenc_counter #(.DEB_LEN(4), .POS_W(8), .DEC_MODE(4), .WRAP(1), .IDX_CLR(1)) d0 (
    .clk_in(clk), .rst_in(rst), .a_in(a), .b_in(b), .c_in(c), .clr_in(clr), .cw_out(cw[0]),
    .acw_out(acw[0]), .idx_out(idx[0]), .err_out(err[0]), .err_flag_out(flag[0]), .pos_out(pos[0]));
  quadenc_counter #(.DEB_LEN(4), .POS_W(8), .DEC_MODE(1), .WRAP(1), .IDX_CLR(1)) d1 (
    .clk_in(clk), .rst_in(rst), .a_in(a), .b_in(b), .c_in(c), .clr_in(clr), .cw_out(cw[1]),
    .acw_out(acw[1]), .idx_out(idx[1]), .err_out(err[1]), .err_flag_out(flag[1]), .pos_out(pos[1]));
  quadenc_counter #(.DEB_LEN(4), .POS_W(8), .DEC_MODE(2), .WRAP(1), .IDX_CLR(1)) d2 (
    .clk_in(clk), .rst_in(rst), .a_in(a), .b_in(b), .c_in(c), .clr_in(clr), .cw_out(cw[2]),
    .acw_out(acw[2]), .idx_out(idx[2]), .err_out(err[2]), .err_flag_out(flag[2]), .pos_out(pos[2]));
  quadenc_counter #(.DEB_LEN(4), .POS_W(8), .DEC_MODE(4), .WRAP(0), .IDX_CLR(0)) d3 (
    .clk_in(clk), .rst_in(rst), .a_in(a), .b_in(b), .c_in(c), .clr_in(clr), .cw_out(cw[3]),
    .acw_out(acw[3]), .idx_out(idx[3]), .err_out(err[3]), .err_flag_out(flag[3]), .pos_out(pos[3]));
  always @(negedge clk)
    for (int i = 0; i < 4; i++)
      if (rst) begin
        cw_n[i] = 0; acw_n[i] = 0; idx_n[i] = 0; err_n[i] = 0;
      end else begin
        cw_n[i] += int'(cw[i]); acw_n[i] += int'(acw[i]);
        idx_n[i] += int'(idx[i]); err_n[i] += int'(err[i]);
      end
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic ab(input logic [1:0] v, input int n);
    {a, b} = v;
    wait_cyc(n);
  endtask
  task automatic do_reset();
    rst = 1'b1; {a, b, c} = 3'b000; clr = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      {a, b, c} = 3'(i * 5);
      @(negedge clk);
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({cw[i], acw[i], idx[i], err[i], flag[i]} !== 5'b0) begin
        fails++; $display("FAIL reset_flags[%0d] got %b exp 00000", i, {cw[i], acw[i], idx[i], err[i], flag[i]});
      end
      tests++;
      if (pos[i] !== 8'd0) begin
        fails++; $display("FAIL reset_pos[%0d] got %0d exp 0", i, pos[i]);
      end
    end
    do_reset();
  endtask
  task automatic test_dec4();
    do_reset();
    {a, b} = 2'b01;
    wait_cyc(7);
    tests++;
    if (cw[0] !== 1'b0) begin fails++; $display("FAIL lat_early got %b exp 0", cw[0]); end
    wait_cyc(1);
    tests++;
    if (cw[0] !== 1'b1) begin fails++; $display("FAIL lat_edge7 got %b exp 1", cw[0]); end
    wait_cyc(2);
    ab(2'b11, 10); ab(2'b10, 10); ab(2'b00, 10);
    for (int i = 0; i < 4; i++) ab(seq[i], 10);
    tests++;
    if (cw_n[0] !== 8 || acw_n[0] !== 0) begin fails++; $display("FAIL dec4_pulses got cw=%0d acw=%0d exp 8/0", cw_n[0], acw_n[0]); end
    tests++;
    if (pos[0] !== 8'd8) begin fails++; $display("FAIL dec4_pos got %0d exp 8", pos[0]); end
    tests++;
    if (cw_n[1] !== 2 || pos[1] !== 8'd2) begin fails++; $display("FAIL dec1_fwd got cw=%0d pos=%0d exp 2/2", cw_n[1], pos[1]); end
    tests++;
    if (cw_n[2] !== 4 || pos[2] !== 8'd4) begin fails++; $display("FAIL dec2_fwd got cw=%0d pos=%0d exp 4/4", cw_n[2], pos[2]); end
    tests++;
    if (pos[3] !== 8'd8) begin fails++; $display("FAIL sat_fwd got %0d exp 8", pos[3]); end
  endtask
  task automatic test_dec1();
    do_reset();
    ab(2'b01, 10); ab(2'b11, 10); ab(2'b10, 10); ab(2'b00, 10);
    ab(2'b10, 10); ab(2'b11, 10); ab(2'b01, 10); ab(2'b00, 10);
    tests++;
    if (cw_n[1] !== 1 || acw_n[1] !== 1 || pos[1] !== 8'd0) begin
      fails++; $display("FAIL dec1_round got cw=%0d acw=%0d pos=%0d exp 1/1/0", cw_n[1], acw_n[1], pos[1]);
    end
    tests++;
    if (cw_n[2] !== 2 || acw_n[2] !== 2 || pos[2] !== 8'd0) begin
      fails++; $display("FAIL dec2_round got cw=%0d acw=%0d pos=%0d exp 2/2/0", cw_n[2], acw_n[2], pos[2]);
    end
    tests++;
    if (cw_n[0] !== 4 || acw_n[0] !== 4 || pos[0] !== 8'd0) begin
      fails++; $display("FAIL dec4_round got cw=%0d acw=%0d pos=%0d exp 4/4/0", cw_n[0], acw_n[0], pos[0]);
    end
  endtask
  task automatic test_glitch_err();
    do_reset();
    ab(2'b10, 3); ab(2'b00, 10);
    tests++;
    if (cw_n[0] + acw_n[0] + err_n[0] !== 0) begin
      fails++; $display("FAIL glitch got cw=%0d acw=%0d err=%0d exp 0/0/0", cw_n[0], acw_n[0], err_n[0]);
    end
    ab(2'b11, 10);
    tests++;
    if (err_n[0] !== 1 || flag[0] !== 1'b1) begin fails++; $display("FAIL err_pulse got err=%0d flag=%b exp 1/1", err_n[0], flag[0]); end
    tests++;
    if (pos[0] !== 8'd0 || cw_n[0] !== 0) begin fails++; $display("FAIL err_nocount got pos=%0d cw=%0d exp 0/0", pos[0], cw_n[0]); end
    tests++;
    if (err_n[1] !== 1) begin fails++; $display("FAIL err_dec1 got %0d exp 1", err_n[1]); end
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    tests++;
    if (flag[0] !== 1'b0) begin fails++; $display("FAIL err_clr got %b exp 0", flag[0]); end
  endtask
  task automatic test_limits();
    do_reset();
    for (int k = 0; k < 127; k++) ab(seq[k % 4], 7);
    wait_cyc(3);
    tests++;
    if (pos[0] !== 8'd127 || pos[3] !== 8'd127) begin fails++; $display("FAIL lim_127 got %0d/%0d exp 127/127", pos[0], pos[3]); end
    ab(2'b00, 10);
    tests++;
    if (pos[0] !== 8'h80) begin fails++; $display("FAIL wrap_max got %h exp 80", pos[0]); end
    tests++;
    if (pos[3] !== 8'd127 || cw_n[3] !== 128) begin fails++; $display("FAIL sat_max got pos=%0d cw=%0d exp 127/128", pos[3], cw_n[3]); end
    ab(2'b10, 10);
    tests++;
    if (pos[0] !== 8'h7f || pos[3] !== 8'd126) begin fails++; $display("FAIL wrap_min got %h/%0d exp 7f/126", pos[0], pos[3]); end
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    tests++;
    if (pos[0] !== 8'd0 || pos[3] !== 8'd0) begin fails++; $display("FAIL clr_pos got %0d/%0d exp 0/0", pos[0], pos[3]); end
  endtask
  task automatic test_index();
    do_reset();
    for (int k = 0; k < 5; k++) ab(seq[k % 4], 10);
    tests++;
    if (pos[0] !== 8'd5) begin fails++; $display("FAIL idx_pre got %0d exp 5", pos[0]); end
    c = 1'b1;
    ab(2'b11, 10);
    c = 1'b0;
    tests++;
    if (idx_n[0] !== 1 || cw_n[0] !== 6) begin fails++; $display("FAIL idx_pulse got idx=%0d cw=%0d exp 1/6", idx_n[0], cw_n[0]); end
    tests++;
    if (pos[0] !== 8'd0) begin fails++; $display("FAIL idx_clear got %0d exp 0", pos[0]); end
    tests++;
    if (idx_n[3] !== 1 || pos[3] !== 8'd6) begin fails++; $display("FAIL idx_noclr got idx=%0d pos=%0d exp 1/6", idx_n[3], pos[3]); end
  endtask
  initial begin
    test_reset();
    test_dec4();
    test_dec1();
    test_glitch_err();
    test_limits();
    test_index();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
